// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO: count-based full/empty, almost flags, sticky
// overflow/underflow, and optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_BITS = 8,
  parameter int NUM_BITS  = 4,
  parameter int AF_LEVEL  = 14,
  parameter int AE_LEVEL  = 2,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [DATA_BITS-1:0] Data_in,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] Data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [NUM_BITS:0]    count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << NUM_BITS;
  localparam int CW    = NUM_BITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [NUM_BITS-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]        count_nxt;
  logic                 wr_acc, rd_acc;

  // Accepts look only at pre-edge flags: a read never frees room for a
  // same-cycle write when full, and a write never feeds a read when empty.
  assign wr_acc = w_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + NUM_BITS'(1);
      if (rd_acc) rd_ptr <= rd_ptr + NUM_BITS'(1);
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      // set beats clear when both land on the same edge
      overflow     <= (w_en && full)   || (overflow  && !clr_err);
      underflow    <= (rd_en && empty) || (underflow && !clr_err);
    end
  end

  // Storage is intentionally unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= Data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic [NUM_BITS-1:0] rd_ptr_inc;
      assign rd_ptr_inc = rd_ptr + NUM_BITS'(1);

      // Data_out always shows the head word; a pop pre-loads the next one.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          Data_out <= '0;
        end else if (wr_acc && empty) begin
          Data_out <= Data_in;
        end else if (rd_acc) begin
          if (count != ONE_C)
            Data_out <= (wr_acc && (wr_ptr == rd_ptr_inc)) ? Data_in : mem[rd_ptr_inc];
          else if (wr_acc)
            Data_out <= Data_in;
        end
      end
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         Data_out <= '0;
        else if (rd_acc) Data_out <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Checks a standard and an FWFT instance, driven in lockstep, against a
// queue-based model of the FIFO.
module tb_sync_fifo_param;
  localparam int DW = 8, NB = 4, DEPTH = 16, AFL = 14, AEL = 2;

  logic clk = 0, rst = 1, w_en = 0, rd_en = 0, clr_err = 0;
  logic [DW-1:0] Data_in = '0;

  logic [DW-1:0] d0_out, d1_out;
  logic d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [NB:0] d0_cnt, d1_cnt;

  sync_fifo_param #(.DATA_BITS(DW), .NUM_BITS(NB), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .Data_in(Data_in), .rd_en(rd_en), .clr_err(clr_err),
    .Data_out(d0_out), .full(d0_full), .empty(d0_empty), .almost_full(d0_af),
    .almost_empty(d0_ae), .count(d0_cnt), .overflow(d0_ovf), .underflow(d0_unf));

  sync_fifo_param #(.DATA_BITS(DW), .NUM_BITS(NB), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .Data_in(Data_in), .rd_en(rd_en), .clr_err(clr_err),
    .Data_out(d1_out), .full(d1_full), .empty(d1_empty), .almost_full(d1_af),
    .almost_empty(d1_ae), .count(d1_cnt), .overflow(d1_ovf), .underflow(d1_unf));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout0 = '0, m_dout1 = '0;
  logic m_ovf = 0, m_unf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("cnt0",  32'(d0_cnt), 32'(n));       chk("cnt1",  32'(d1_cnt), 32'(n));
    chk("full0", 32'(d0_full), 32'(n == DEPTH)); chk("full1", 32'(d1_full), 32'(n == DEPTH));
    chk("empty0", 32'(d0_empty), 32'(n == 0));   chk("empty1", 32'(d1_empty), 32'(n == 0));
    chk("af0", 32'(d0_af), 32'(n >= AFL));   chk("af1", 32'(d1_af), 32'(n >= AFL));
    chk("ae0", 32'(d0_ae), 32'(n <= AEL));   chk("ae1", 32'(d1_ae), 32'(n <= AEL));
    chk("ovf0", 32'(d0_ovf), 32'(m_ovf));    chk("ovf1", 32'(d1_ovf), 32'(m_ovf));
    chk("unf0", 32'(d0_unf), 32'(m_unf));    chk("unf1", 32'(d1_unf), 32'(m_unf));
    chk("dout0", 32'(d0_out), 32'(m_dout0)); chk("dout1", 32'(d1_out), 32'(m_dout1));
  endtask

  // One clock with the given inputs; model advances from pre-edge state.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    bit was_full, was_empty;
    w_en = w; Data_in = d; rd_en = r; clr_err = c;
    was_full = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_ovf = (w && was_full) || (m_ovf && !c);
    m_unf = (r && was_empty) || (m_unf && !c);
    if (r && !was_empty) m_dout0 = q.pop_front();
    if (w && !was_full) q.push_back(d);
    if (q.size() > 0) m_dout1 = q[0];
    @(posedge clk);
    @(negedge clk);
    w_en = 0; rd_en = 0; clr_err = 0;
    check_all();
  endtask

  task automatic model_reset();
    q.delete(); m_dout0 = '0; m_dout1 = '0; m_ovf = 0; m_unf = 0;
  endtask

  // Async reset landing between edges; outputs must clear before any clock.
  task automatic async_reset();
    #2 rst = 1;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 0;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 0;
    @(negedge clk);

    // Mid-stream reset at count=5, then first write after release
    for (int i = 0; i < 5; i++) cycle(1, DW'(8'h10 + i), 0, 0);
    async_reset();
    cycle(1, 8'hA1, 0, 0);
    async_reset();

    // Fill, overflow attempt, full-cycle w+r, drain, underflow, clr_err
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0, 0);
    cycle(1, 8'hFF, 0, 0);
    cycle(1, 8'hEE, 1, 0);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);

    // Simultaneous access at count=8
    for (int i = 0; i < 8; i++) cycle(1, DW'(8'h40 + i), 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, DW'(8'h50 + i), 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);

    // Wrap-around at occupancy 3
    async_reset();
    for (int i = 0; i < 3; i++) cycle(1, DW'(i), 0, 0);
    for (int i = 3; i < 43; i++) cycle(1, DW'(i), 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);

    // FWFT presentation and count==1 read+write
    async_reset();
    cycle(1, 8'h5A, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 8'h3C, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    // Random traffic with drifting bias to visit full and empty
    for (int ph = 0; ph < 12; ph++) begin
      int wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      for (int i = 0; i < 150; i++)
        cycle($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < (100 - wp),
              $urandom_range(0, 99) < 5);
      if (ph == 7) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO that generalises our FIFO storage block. It adds full/empty generation, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It is the standard buffering element for same-clock datapaths, alongside the asynchronous FIFO.

Parameters:
DATA_BITS, 8, word width
NUM_BITS, 4, address width; DEPTH = 2**NUM_BITS entries (power of two only)
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
w_en  in  1  write request
Data_in  in  DATA_BITS  write data
rd_en  in  1  read request (FWFT: pop/acknowledge)
clr_err  in  1  clears the overflow and underflow flags
Data_out  out  DATA_BITS  read data, registered
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  NUM_BITS+1  occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (async, immediate, also mid-operation): pointers=0, count=0, Data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not reset and are don't-care.
- Pointers: binary write and read pointers, NUM_BITS wide, wrap modulo DEPTH. full and empty are derived from the registered count, not from pointer compare.
- Accept rules: a write is accepted when w_en && !full; a read is accepted when rd_en && !empty. Both use the flag state before the edge.
- A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- count: +1 on a write-only edge, -1 on a read-only edge, unchanged when both are accepted or neither is.
- All flags are registered and reflect count after the edge. There is no combinational path from inputs to outputs.
- Error flags: overflow is set on any edge with w_en && full; underflow is set on any edge with rd_en && empty. clr_err clears both flags on the edge. If set and clear occur in the same cycle, set wins. Rejected accesses change no pointer, count or memory.
- FWFT=0: an accepted read loads Data_out with mem[rd_ptr] at that edge (one-cycle latency). Data_out holds its value otherwise, including across writes and rejected reads.
- FWFT=1: whenever empty=0, Data_out already presents the head word, and rd_en consumes it.
  - Write into empty FIFO (count==0): Data_out <= Data_in on the same edge; empty falls after that edge.
  - Accepted read with count>=2: Data_out <= next entry (mem[rd_ptr+1]). The write-first bypass applies if that entry is being written on this edge.
  - Accepted read with count==1 plus a simultaneous accepted write: Data_out <= Data_in.
  - Accepted read with count==1 and no write: Data_out holds its stale value; empty rises.
  - In FWFT mode count includes the presented word, so full still means DEPTH words are held.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap; ordering is preserved across the wrap.

Test Plan:
- Reset/flags: assert rst mid-stream with count=5 -> outputs go immediately to count=0, empty=1, almost_empty=1, Data_out=0, overflow=0; after release, write 0xA1 -> count=1, empty=0.
- Fill/drain, FWFT=0: write 0x00..0x0F (16 words) -> full=1, count=16, almost_full from count=14; read 16 times -> Data_out equals 0x00..0x0F, each one cycle after its read, then empty=1.
- Overflow/underflow: with the FIFO full, pulse w_en with 0xFF -> overflow=1, count stays 16, 0xFF never read back. Drain the FIFO, then pulse rd_en -> underflow=1. Assert clr_err and rd_en together while empty -> underflow stays 1. Assert clr_err alone -> both flags clear.
- Simultaneous access: at count=16, assert w_en+rd_en -> read accepted, write rejected, count=15, overflow=1. At count=8, assert both -> count stays 8 and data order is intact.
- Wrap: loop 40 writes/reads at occupancy 3 with an incrementing pattern -> output sequence is strictly incrementing, no drops or duplicates.
- FWFT=1: write 0x5A into empty -> next cycle empty=0, Data_out=0x5A with no rd_en. At count=1, assert rd_en with a simultaneous write of 0x3C -> Data_out=0x3C, count=1, empty=0.
